// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter: merges pipeline writeback with mul/div completions,
// buffering losing mul/div results in a small in-order FIFO and reporting pending writes to ID.
module reg_wb_arbiter #(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pipe_we,
   input  logic [4:0]  pipe_waddr,
   input  logic [31:0] pipe_wd,
   input  logic        md_valid,
   input  logic [4:0]  md_waddr,
   input  logic [31:0] md_wd,
   output logic        md_ready,
   output logic        drain_req,
   input  logic [4:0]  addr1,
   input  logic [4:0]  addr2,
   output logic        pend1,
   output logic        pend2,
   output logic        we,
   output logic [4:0]  waddr,
   output logic [31:0] wd
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(STARVE_LIMIT + 1);

   // Handshake: an md result transfers on a cycle where md_valid && md_ready.
   logic [4:0]    fifo_addr [DEPTH];
   logic [31:0]   fifo_data [DEPTH];
   logic [AW:0]   wp, rp, count;
   logic [CW-1:0] starve_cnt;
   logic          empty, full;
   logic          pipe_eff, md_acc, md_eff;
   logic          sel_pipe, sel_head, sel_bypass, push;
   logic          hit1, hit2;

   assign empty = (wp == rp);
   assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign count = wp - rp;

   assign md_ready  = !full && !rst;
   assign drain_req = (starve_cnt >= CW'(STARVE_LIMIT));

   assign pipe_eff   = pipe_we && (pipe_waddr != 5'd0);
   assign md_acc     = md_valid && md_ready;
   assign md_eff     = md_acc && (md_waddr != 5'd0);
   assign sel_pipe   = pipe_eff;
   assign sel_head   = !pipe_eff && !empty;
   assign sel_bypass = !pipe_eff && empty && md_eff;
   assign push       = md_eff && !sel_bypass;

   always_ff @(posedge clk) begin
      if (rst) begin
         wp         <= '0;
         rp         <= '0;
         starve_cnt <= '0;
         we         <= 1'b0;
         waddr      <= 5'd0;
         wd         <= 32'd0;
      end else begin
         we <= sel_pipe || sel_head || sel_bypass;
         if (sel_pipe) begin
            waddr <= pipe_waddr;
            wd    <= pipe_wd;
         end else if (sel_head) begin
            waddr <= fifo_addr[rp[AW-1:0]];
            wd    <= fifo_data[rp[AW-1:0]];
         end else if (sel_bypass) begin
            waddr <= md_waddr;
            wd    <= md_wd;
         end
         if (push)
            wp <= wp + 1'b1;
         if (sel_head)
            rp <= rp + 1'b1;
         // The head only loses when an effective pipe write is present.
         if (empty || !pipe_eff)
            starve_cnt <= '0;
         else if (starve_cnt < CW'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wp[AW-1:0]] <= md_waddr;
         fifo_data[wp[AW-1:0]] <= md_wd;
      end
   end

   // An entry is live when its distance from the read pointer is below the occupancy.
   always_comb begin
      logic [AW-1:0] off;
      hit1 = 1'b0;
      hit2 = 1'b0;
      off  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off = AW'(i) - rp[AW-1:0];
         if ({1'b0, off} < count) begin
            if (fifo_addr[i] == addr1) hit1 = 1'b1;
            if (fifo_addr[i] == addr2) hit2 = 1'b1;
         end
      end
   end

   assign pend1 = (addr1 != 5'd0) && (hit1 || (we && (waddr == addr1)));
   assign pend2 = (addr2 != 5'd0) && (hit2 || (we && (waddr == addr2)));

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed vector table for the corner sequences, then
// randomized traffic compared against a queue-based reference model.
module tb_reg_wb_arbiter;
   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pipe_we = 1'b0;
   logic [4:0]  pipe_waddr = '0;
   logic [31:0] pipe_wd = '0;
   logic        md_valid = 1'b0;
   logic [4:0]  md_waddr = '0;
   logic [31:0] md_wd = '0;
   logic        md_ready, drain_req, pend1, pend2, we;
   logic [4:0]  addr1 = '0, addr2 = '0, waddr;
   logic [31:0] wd;

   int n_chk  = 0;
   int n_fail = 0;

   reg_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wd(pipe_wd),
      .md_valid(md_valid), .md_waddr(md_waddr), .md_wd(md_wd),
      .md_ready(md_ready), .drain_req(drain_req),
      .addr1(addr1), .addr2(addr2), .pend1(pend1), .pend2(pend2),
      .we(we), .waddr(waddr), .wd(wd)
   );

   // clock/reset
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // directed vector table
   typedef struct {
      logic        rst, pwe;
      logic [4:0]  pa;
      logic [31:0] pd;
      logic        mv;
      logic [4:0]  ma;
      logic [31:0] mdd;
      logic [4:0]  a1, a2;
      int          chk;      // 0 skip, 1 check, 2 also check waddr/wd with we=0
      logic        ewe;
      logic [4:0]  ewa;
      logic [31:0] ewd;
      logic        erdy, edr, ep1, ep2;
   } vec_t;
   vec_t tbl[$];

   function automatic void add(input logic r, input logic pwe, input logic [4:0] pa,
                               input logic [31:0] pd, input logic mv, input logic [4:0] ma,
                               input logic [31:0] mdd, input logic [4:0] a1, input logic [4:0] a2,
                               input int c, input logic ewe, input logic [4:0] ewa,
                               input logic [31:0] ewd, input logic erdy, input logic edr,
                               input logic ep1, input logic ep2);
      vec_t v;
      v.rst = r; v.pwe = pwe; v.pa = pa; v.pd = pd; v.mv = mv; v.ma = ma; v.mdd = mdd;
      v.a1 = a1; v.a2 = a2; v.chk = c; v.ewe = ewe; v.ewa = ewa; v.ewd = ewd;
      v.erdy = erdy; v.edr = edr; v.ep1 = ep1; v.ep2 = ep2;
      tbl.push_back(v);
   endfunction

   // driver
   task automatic drive(input logic r, input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                        input logic mv, input logic [4:0] ma, input logic [31:0] mdd,
                        input logic [4:0] a1, input logic [4:0] a2);
      rst = r; pipe_we = pwe; pipe_waddr = pa; pipe_wd = pd;
      md_valid = mv; md_waddr = ma; md_wd = mdd; addr1 = a1; addr2 = a2;
   endtask

   // reference model: FIFO as a queue of {addr, data}
   logic [36:0] exp_q[$];
   logic        m_we = 1'b0;
   logic [4:0]  m_waddr = '0;
   logic [31:0] m_wd = '0;
   int          m_cnt = 0;

   function automatic logic m_pend(input logic [4:0] a);
      if (a == 5'd0) return 1'b0;
      if (m_we && m_waddr == a) return 1'b1;
      foreach (exp_q[i]) if (exp_q[i][36:32] == a) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_step(input logic m_rdy);
      logic ep, em;
      logic [36:0] h;
      if (rst) begin
         exp_q.delete(); m_cnt = 0; m_we = 1'b0; m_waddr = '0; m_wd = '0;
         return;
      end
      ep = pipe_we && pipe_waddr != 0;
      em = md_valid && m_rdy && md_waddr != 0;
      if (ep) begin
         m_we = 1'b1; m_waddr = pipe_waddr; m_wd = pipe_wd;
         m_cnt = (exp_q.size() > 0) ? ((m_cnt < LIMIT) ? m_cnt + 1 : LIMIT) : 0;
         if (em) exp_q.push_back({md_waddr, md_wd});
      end else if (exp_q.size() > 0) begin
         h = exp_q.pop_front();
         m_we = 1'b1; m_waddr = h[36:32]; m_wd = h[31:0]; m_cnt = 0;
         if (em) exp_q.push_back({md_waddr, md_wd});
      end else if (em) begin
         m_we = 1'b1; m_waddr = md_waddr; m_wd = md_wd; m_cnt = 0;
      end else begin
         m_we = 1'b0; m_cnt = 0;
      end
   endtask

   initial begin
      // reset: two cycles, check reset state in the second
      add(1,0,0,0, 0,0,0, 0,0,       0, 0,0,0,           0,0,0,0);
      add(1,0,0,0, 0,0,0, 5,0,       2, 0,0,0,           0,0,0,0);
      // pipe write x5
      add(0,1,5,32'hDEADBEEF, 0,0,0, 5,0, 1, 0,0,0,      1,0,0,0);
      add(0,0,0,0, 0,0,0, 5,0,       1, 1,5,32'hDEADBEEF, 1,0,1,0);
      // bypass x7
      add(0,0,0,0, 1,7,32'h12345678, 7,0, 1, 0,0,0,      1,0,0,0);
      add(0,0,0,0, 0,0,0, 7,0,       1, 1,7,32'h12345678, 1,0,1,0);
      add(0,0,0,0, 0,0,0, 7,0,       1, 0,0,0,           1,0,0,0);
      // conflict x3 vs x9
      add(0,1,3,1, 1,9,2, 9,3,       1, 0,0,0,           1,0,0,0);
      add(0,0,0,0, 0,0,0, 9,3,       1, 1,3,1,           1,0,1,1);
      add(0,0,0,0, 0,0,0, 9,3,       1, 1,9,2,           1,0,1,0);
      add(0,0,0,0, 0,0,0, 9,3,       1, 0,0,0,           1,0,0,0);
      // full FIFO and starvation
      add(0,1,10,32'hA0, 1,20,32'h20, 20,21, 1, 0,0,0,          1,0,0,0);
      add(0,1,11,32'hA1, 1,21,32'h21, 20,21, 1, 1,10,32'hA0,    1,0,1,0);
      add(0,1,12,32'hA2, 1,22,32'h22, 20,21, 1, 1,11,32'hA1,    0,0,1,1);
      add(0,1,13,32'hA3, 0,0,0,       20,22, 1, 1,12,32'hA2,    0,0,1,0);
      add(0,1,14,32'hA4, 0,0,0,       20,21, 1, 1,13,32'hA3,    0,0,1,1);
      add(0,1,15,32'hA5, 0,0,0,       20,21, 1, 1,14,32'hA4,    0,1,1,1);
      add(0,0,0,0, 0,0,0,             20,21, 1, 1,15,32'hA5,    0,1,1,1);
      add(0,0,0,0, 0,0,0,             20,21, 1, 1,20,32'h20,    1,0,1,1);
      add(0,0,0,0, 0,0,0,             20,21, 1, 1,21,32'h21,    1,0,0,1);
      add(0,0,0,0, 0,0,0,             20,21, 1, 0,0,0,          1,0,0,0);
      // x0 writes dropped
      add(0,1,0,32'hFFFF, 1,0,5, 0,0, 1, 0,0,0,          1,0,0,0);
      add(0,1,0,32'hFFFF, 1,0,6, 0,0, 1, 0,0,0,          1,0,0,0);
      add(0,0,0,0, 0,0,0, 0,0,       1, 0,0,0,           1,0,0,0);
      // reset mid-drain
      add(0,1,1,32'h11, 1,25,32'h25, 25,26, 1, 0,0,0,        1,0,0,0);
      add(0,1,2,32'h12, 1,26,32'h26, 25,26, 1, 1,1,32'h11,   1,0,1,0);
      add(1,0,0,0, 0,0,0,             25,26, 1, 1,2,32'h12,   0,0,1,1);
      add(0,0,0,0, 0,0,0,             25,26, 2, 0,0,0,        1,0,0,0);
      add(0,0,0,0, 0,0,0,             25,26, 1, 0,0,0,        1,0,0,0);

      foreach (tbl[k]) begin
         @(posedge clk); #1;
         drive(tbl[k].rst, tbl[k].pwe, tbl[k].pa, tbl[k].pd, tbl[k].mv, tbl[k].ma,
               tbl[k].mdd, tbl[k].a1, tbl[k].a2);
         @(negedge clk);
         if (tbl[k].chk != 0) begin
            chk($sformatf("vec%0d we", k), 32'(we), 32'(tbl[k].ewe));
            if (tbl[k].ewe || tbl[k].chk == 2) begin
               chk($sformatf("vec%0d waddr", k), 32'(waddr), 32'(tbl[k].ewa));
               chk($sformatf("vec%0d wd", k), wd, tbl[k].ewd);
            end
            chk($sformatf("vec%0d md_ready", k), 32'(md_ready), 32'(tbl[k].erdy));
            chk($sformatf("vec%0d drain_req", k), 32'(drain_req), 32'(tbl[k].edr));
            chk($sformatf("vec%0d pend1", k), 32'(pend1), 32'(tbl[k].ep1));
            chk($sformatf("vec%0d pend2", k), 32'(pend2), 32'(tbl[k].ep2));
         end
      end

      // randomized traffic against the model (model state matches the idle DUT here)
      for (int c = 0; c < 800; c++) begin
         logic m_rdy, m_drain, pwe;
         @(posedge clk); #1;
         m_drain = (m_cnt >= LIMIT);
         pwe = (m_drain && $urandom_range(0, 7) != 0) ? 1'b0 : 1'($urandom_range(0, 1));
         drive((c == 0) || ($urandom_range(0, 79) == 0), pwe, 5'($urandom_range(0, 7)),
               $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         @(negedge clk);
         m_rdy = !rst && (exp_q.size() < DEPTH);
         chk("rnd we", 32'(we), 32'(m_we));
         if (m_we) begin
            chk("rnd waddr", 32'(waddr), 32'(m_waddr));
            chk("rnd wd", wd, m_wd);
         end
         chk("rnd md_ready", 32'(md_ready), 32'(m_rdy));
         chk("rnd drain_req", 32'(drain_req), 32'(m_drain));
         chk("rnd pend1", 32'(pend1), 32'(m_pend(addr1)));
         chk("rnd pend2", 32'(pend2), 32'(m_pend(addr2)));
         model_step(m_rdy);
      end

      // final report
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
